// File: rtl/mdu_iter_pkg.sv
// Shared RV32M multiply/divide definitions: op encodings, FSM states, latency.
// Also holds the operand sign-conditioning helpers used at acceptance.
package mdu_iter_pkg;

  localparam int MDU_XLEN    = 32;
  localparam int MDU_LATENCY = 33;
  localparam int MDU_CNT_W   = 6;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  // Latched operation: which result to select and whether to negate it.
  typedef struct packed {
    funct3_e funct3;
    logic    neg;
  } op_t;

  function automatic logic op_is_div(input funct3_e f);
    logic [2:0] code;
    code = f;
    return code[2];
  endfunction

  function automatic logic rs1_signed(input funct3_e f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic rs2_signed(input funct3_e f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic [MDU_XLEN-1:0] magnitude(input logic [MDU_XLEN-1:0] v,
                                                    input logic               neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Requester owns START/KILL/operands; the unit owns BUSY/DONE/RESULT.
interface mdu_iter_if;
  import mdu_iter_pkg::*;

  logic                START;
  logic                KILL;
  logic [2:0]          FUNCT3;
  logic [MDU_XLEN-1:0] OPERAND1;
  logic [MDU_XLEN-1:0] OPERAND2;
  logic                BUSY;
  logic                DONE;
  logic [MDU_XLEN-1:0] RESULT;

  modport master (
    output START, KILL, FUNCT3, OPERAND1, OPERAND2,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, KILL, FUNCT3, OPERAND1, OPERAND2,
    output BUSY, DONE, RESULT
  );

endinterface

// File: rtl/mdu_iter_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Latency: 32 steps after load; no backpressure, the caller sequences load/step.
module mdu_div_core
  import mdu_iter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [MDU_XLEN-1:0] dividend,
  input  logic [MDU_XLEN-1:0] divisor,
  output logic [MDU_XLEN-1:0] quotient,
  output logic [MDU_XLEN-1:0] remainder
);

  logic [MDU_XLEN-1:0] quo_q;
  logic [MDU_XLEN-1:0] rem_q;
  logic [MDU_XLEN-1:0] dvsr_q;
  logic [MDU_XLEN:0]   shifted;
  logic                fits;

  // Partial remainder stays below the divisor, so the difference always fits in XLEN bits.
  assign shifted = {rem_q, quo_q[MDU_XLEN-1]};
  assign fits    = (shifted >= {1'b0, dvsr_q});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? (shifted[MDU_XLEN-1:0] - dvsr_q) : shifted[MDU_XLEN-1:0];
      quo_q <= {quo_q[MDU_XLEN-2:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per edge; DONE 33 edges after accept.
// No queueing: START is ignored while BUSY; KILL aborts, RESULT holds its last DONE value.
module mdu_iter
  import mdu_iter_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  mdu_iter_if.slave   bus
);

  localparam int LATENCY = MDU_LATENCY;

  state_e               state_q;
  state_e               state_d;
  logic [MDU_CNT_W-1:0] cnt_q;
  op_t                  op_q;
  logic [MDU_XLEN-1:0]  mcand_q;
  logic [MDU_XLEN-1:0]  mul_hi_q;
  logic [MDU_XLEN-1:0]  mul_lo_q;
  logic [MDU_XLEN-1:0]  result_q;
  logic [MDU_XLEN:0]    mul_sum;
  logic [MDU_XLEN-1:0]  quo;
  logic [MDU_XLEN-1:0]  rem;

  logic                 accept;
  logic                 calc_last;
  logic                 step_en;
  logic                 busy;
  logic                 done;

  funct3_e              f3_in;
  logic                 a_neg;
  logic                 b_neg;
  logic [MDU_XLEN-1:0]  a_mag;
  logic [MDU_XLEN-1:0]  b_mag;
  logic                 neg_in;

  logic [2*MDU_XLEN-1:0] prod;
  logic [2*MDU_XLEN-1:0] prod_fix;
  logic [MDU_XLEN-1:0]   quo_fix;
  logic [MDU_XLEN-1:0]   rem_fix;
  logic [MDU_XLEN-1:0]   finish_val;

  // Sign conditioning at acceptance: both datapaths only ever see magnitudes.
  always_comb begin
    f3_in = funct3_e'(bus.FUNCT3);
    a_neg = rs1_signed(f3_in) & bus.OPERAND1[MDU_XLEN-1];
    b_neg = rs2_signed(f3_in) & bus.OPERAND2[MDU_XLEN-1];
    a_mag = magnitude(bus.OPERAND1, a_neg);
    b_mag = magnitude(bus.OPERAND2, b_neg);
    if (!op_is_div(f3_in)) begin
      neg_in = a_neg ^ b_neg;
    end else if ((f3_in == F3_REM) || (f3_in == F3_REMU)) begin
      neg_in = a_neg;
    end else begin
      // A zero divisor must leave the all-ones quotient un-negated.
      neg_in = (a_neg ^ b_neg) & (bus.OPERAND2 != '0);
    end
  end

  assign accept    = (state_q == ST_IDLE) && bus.START && !bus.KILL;
  assign calc_last = (cnt_q == MDU_CNT_W'(LATENCY - 1));
  assign step_en   = (state_q == ST_CALC) && !calc_last;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept)    state_d = ST_CALC;
      ST_CALC:   if (calc_last) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.KILL) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_CALC:   busy = 1'b1;
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.RESULT = result_q;

  // Shift-add multiply: {carry, hi, lo} shifts right once per step, lo starts as the multiplier.
  assign mul_sum = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mcand_q} : {(MDU_XLEN+1){1'b0}});

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mul_hi_q <= '0;
      mul_lo_q <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      op_q     <= '{funct3: f3_in, neg: neg_in};
      mcand_q  <= a_mag;
      mul_hi_q <= '0;
      mul_lo_q <= b_mag;
    end else if (step_en) begin
      cnt_q    <= cnt_q + MDU_CNT_W'(1);
      mul_hi_q <= mul_sum[MDU_XLEN:1];
      mul_lo_q <= {mul_sum[0], mul_lo_q[MDU_XLEN-1:1]};
    end
  end

  mdu_div_core u_div_core (
    .clk       (CLK),
    .rst_n     (RESET),
    .load      (accept),
    .step      (step_en),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    prod     = {mul_hi_q, mul_lo_q};
    prod_fix = op_q.neg ? -prod : prod;
    quo_fix  = op_q.neg ? -quo  : quo;
    rem_fix  = op_q.neg ? -rem  : rem;
    unique case (op_q.funct3)
      F3_MUL:                       finish_val = prod_fix[MDU_XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: finish_val = prod_fix[2*MDU_XLEN-1:MDU_XLEN];
      F3_DIV, F3_DIVU:              finish_val = quo_fix;
      default:                      finish_val = rem_fix;
    endcase
  end

  // RESULT loads on the edge entering FINISH and then holds until the next completion.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      result_q <= '0;
    end else if ((state_q == ST_CALC) && calc_last && !bus.KILL) begin
      result_q <= finish_val;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed RV32M vectors, latency, KILL and RESET behaviour.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mdu_iter_if bus ();

  mdu_iter dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns the edge index (counted from the accepting edge) where DONE is first seen, 0 if never.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.DONE === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    bus.START    = 1'b1;
    bus.FUNCT3   = f3;
    bus.OPERAND1 = a;
    bus.OPERAND2 = b;
    tick();
    check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
    bus.START    = 1'b0;
    bus.FUNCT3   = ~f3;
    bus.OPERAND1 = ~a;
    bus.OPERAND2 = b + 32'd1;
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'd33);
    check({tag, "_res"}, bus.RESULT, exp);
    tick();
    check({tag, "_done_clr"}, {30'd0, bus.DONE, bus.BUSY}, 32'd0);
    check({tag, "_hold"}, bus.RESULT, exp);
  endtask

  initial begin
    int n;
    int dones;

    reset        = 1'b0;
    bus.START    = 1'b0;
    bus.KILL     = 1'b0;
    bus.FUNCT3   = 3'b000;
    bus.OPERAND1 = 32'd0;
    bus.OPERAND2 = 32'd0;
    tick();
    tick();
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_done", 32'(bus.DONE), 32'd0);
    check("reset_result", bus.RESULT, 32'd0);
    reset = 1'b1;
    tick();

    run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42);
    run_op("mulhu_ff",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulh_ff",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    run_op("div_100_7",   3'b100, 32'd100,      32'd7,        32'd14);
    run_op("rem_100_7",   3'b110, 32'd100,      32'd7,        32'd2);
    run_op("div_m100_7",  3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2);
    run_op("rem_m100_7",  3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE);
    run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    run_op("div_m7_0",    3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
    run_op("divu_123_0",  3'b101, 32'd123,      32'd0,        32'hFFFFFFFF);
    run_op("remu_123_0",  3'b111, 32'd123,      32'd0,        32'd123);

    // KILL at edge 10 of a MUL 5x5.
    bus.START    = 1'b1;
    bus.FUNCT3   = 3'b000;
    bus.OPERAND1 = 32'd5;
    bus.OPERAND2 = 32'd5;
    tick();
    bus.START = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    bus.KILL = 1'b1;
    tick();
    bus.KILL = 1'b0;
    check("kill_busy", 32'(bus.BUSY), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.DONE === 1'b1) dones++;
    end
    check("kill_no_done", 32'(dones), 32'd0);
    check("kill_result", bus.RESULT, 32'd123);
    run_op("mul_5x5", 3'b000, 32'd5, 32'd5, 32'd25);

    // KILL wins over START in IDLE.
    bus.START = 1'b1;
    bus.KILL  = 1'b1;
    tick();
    check("kill_prio_busy", 32'(bus.BUSY), 32'd0);
    bus.START = 1'b0;
    bus.KILL  = 1'b0;
    tick();

    // START held high through BUSY yields exactly one completion.
    bus.START    = 1'b1;
    bus.FUNCT3   = 3'b000;
    bus.OPERAND1 = 32'd3;
    bus.OPERAND2 = 32'd4;
    tick();
    wait_done(n);
    bus.START = 1'b0;
    check("held_lat", 32'(n), 32'd33);
    check("held_res", bus.RESULT, 32'd12);
    dones = (n != 0) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.DONE === 1'b1) dones++;
    end
    check("held_one_done", 32'(dones), 32'd1);

    // RESET at edge 20 of a DIV 100/7.
    bus.START    = 1'b1;
    bus.FUNCT3   = 3'b100;
    bus.OPERAND1 = 32'd100;
    bus.OPERAND2 = 32'd7;
    tick();
    bus.START = 1'b0;
    for (int i = 1; i <= 19; i++) tick();
    reset = 1'b0;
    tick();
    check("rst_mid_busy", 32'(bus.BUSY), 32'd0);
    check("rst_mid_done", 32'(bus.DONE), 32'd0);
    check("rst_mid_result", bus.RESULT, 32'd0);

    // RESET beats START; first edge with RESET high accepts.
    bus.START = 1'b1;
    tick();
    check("rst_prio_busy", 32'(bus.BUSY), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_first_accept", 32'(bus.BUSY), 32'd1);
    bus.START = 1'b0;
    wait_done(n);
    check("rst_div_lat", 32'(n), 32'd33);
    check("rst_div_res", bus.RESULT, 32'd14);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-low reset sampled on CLK rising edge.
REQ-003 SHALL have port START, input, 1, request to begin an M-extension operation.
REQ-004 SHALL have port KILL, input, 1, pipeline flush; aborts any in-flight operation.
REQ-005 SHALL have port FUNCT3, input, 3, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port OPERAND1, input, 32, rs1 value from the register file read port DATA_OUT1 via ID/EX.
REQ-007 SHALL have port OPERAND2, input, 32, rs2 value from the register file read port DATA_OUT2 via ID/EX.
REQ-008 SHALL have port BUSY, output, 1, high while an operation is accepted and not yet done.
REQ-009 SHALL have port DONE, output, 1, one-cycle pulse marking RESULT valid.
REQ-010 SHALL have port RESULT, output, 32, operation result, destined for WRITE_DATA of the register file.
REQ-011 SHALL have parameter LATENCY, default 33, edges from accepting edge to DONE edge; fixed, not user-tunable.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FINISH.
REQ-013 IDLE: START=1 and KILL=0 on an edge SHALL latch FUNCT3, OPERAND1, OPERAND2, clear iteration counter, enter CALC, set BUSY.
REQ-014 CALC SHALL perform one radix-2 step per edge (shift-add multiply or restoring divide on magnitudes), 32 steps total, then enter FINISH.
REQ-015 FINISH SHALL drive DONE=1 and updated RESULT for exactly one cycle, clear BUSY, return to IDLE on next edge.
REQ-016 DONE SHALL rise on edge 33 after the accepting edge; no early completion for special cases.
REQ-017 Operand/FUNCT3 changes after acceptance SHALL have no effect; START while BUSY SHALL be ignored (no queueing).
REQ-018 START may be re-asserted during the FINISH cycle and SHALL be accepted on the edge returning to IDLE only if still high in IDLE (back-to-back spacing minimum 34 edges).
REQ-019 MUL SHALL return low 32 bits; MULH/MULHSU/MULHU high 32 bits of 64-bit product with signed×signed, signed×unsigned, unsigned×unsigned operands.
REQ-020 DIV/REM SHALL truncate toward zero; remainder sign SHALL follow dividend.
REQ-021 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return OPERAND1.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-023 KILL=1 on any edge SHALL force IDLE, BUSY=0, DONE=0, RESULT unchanged; KILL has priority over START in the same cycle.
REQ-024 RESULT SHALL hold its last DONE value until the next DONE.

Reset
REQ-025 RESET=0 on an edge SHALL force IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, regardless of state, including mid-CALC.
REQ-026 RESET SHALL take priority over KILL and START; first START accepted is on the first edge with RESET=1.

Structure
REQ-027 FUNCT3 encodings, FSM state encodings and LATENCY SHALL live in shared header mdu_defs.vh, reused by the ID decoder and hazard unit.
REQ-028 Divide datapath (restoring step, remainder/quotient registers) SHALL be sub-module mdu_div_core; multiply step SHALL remain inline.
REQ-029 Sign conditioning SHALL occur once at acceptance and result negation once at FINISH.

Verification
REQ-030 MUL 7 × 6 -> DONE on edge 33 after acceptance, RESULT=42; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
REQ-031 DIV 100 / 7 -> 14; REM -> 2; DIV -100 / 7 -> 0xFFFFFFF2 (-14); REM -100 / 7 -> 0xFFFFFFFE (-2).
REQ-032 DIVU 123 / 0 -> 0xFFFFFFFF; REMU 123 / 0 -> 123; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-033 MUL 5 × 5 started, KILL at edge 10 -> BUSY=0 next cycle, no DONE within 40 edges, RESULT retains prior value; new START then completes normally with 25.
REQ-034 DIV 100 / 7 started, RESET=0 at edge 20 -> BUSY=0, DONE=0, RESULT=0; START held high during BUSY in an unreset run -> exactly one DONE.
